// File: rtl/seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared definitions for the serial sequence detector:
//   - default widths for the pattern (DEF_PAT_W), match counter (DEF_CNT_W)
//     and pattern length field (DEF_LEN_W)
//   - the controller state enumeration (state_e)
// -----------------------------------------------------------------------------
package seq_ctrl_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_LEN_W = $clog2(DEF_PAT_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_match_core.sv
// -----------------------------------------------------------------------------
// seq_match_core
// History shift register, fill counter and masked pattern compare.
//   clk, rst     : clock, synchronous active-high reset
//   i_clear      : zero history and fill (arm / disarm)
//   i_shift      : accept i_bit this cycle
//   i_fill_zero  : with i_shift, restart fill from 0 (non-overlapping match)
//   i_bit        : serial data bit
//   i_pattern    : pattern, bit 0 newest
//   i_len        : pattern length, already clamped to 1..PAT_W
//   o_match      : combinational; the history including i_bit matches
// -----------------------------------------------------------------------------
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter  int PAT_W = DEF_PAT_W,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_fill_zero,
    input  logic             i_bit,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_match
);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] w_hist_next;
    logic [LEN_W-1:0] w_fill_next;
    logic [PAT_W-1:0] w_mask;

    assign w_hist_next = {r_hist[PAT_W-2:0], i_bit};
    assign w_fill_next = (r_fill >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : r_fill + LEN_W'(1);

    // Only the low i_len bits take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < i_len);
        end
    end

    // Evaluated on the would-be history so the completing bit counts.
    assign o_match = (w_fill_next >= i_len) &&
                     (((w_hist_next ^ i_pattern) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_hist_next;
            r_fill <= i_fill_zero ? '0 : w_fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
// Configurable serial pattern detector with arm / abort / done control.
//   clk, rst                      : clock, synchronous active-high reset
//   cfg_valid / cfg_ready         : config handshake (see below)
//   cfg_pattern, cfg_len,
//   cfg_overlap, cfg_target       : configuration fields
//   start, abort, clear           : arm, disarm, acknowledge done
//   in, in_valid                  : serial data
//   out                           : registered one-cycle match pulse
//   match_cnt                     : matches since last start (saturating)
//   busy, done                    : ARMED / DONE indications
//   o_state_dbg                   : current controller state
//
// Handshake: config is latched on a rising edge where cfg_valid && cfg_ready;
// cfg_ready is high exactly while IDLE, so an offer made outside IDLE simply
// waits, and the offerer must hold its fields stable until accepted.
// -----------------------------------------------------------------------------
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter  int PAT_W = DEF_PAT_W,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             clear,
    input  logic             in,
    input  logic             in_valid,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_state_dbg
);

    state_e           r_state;
    state_e           w_state_next;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;

    logic             w_accept;
    logic             w_shift;
    logic             w_core_match;
    logic             w_take;
    logic             w_clear_core;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [LEN_W-1:0] w_len_clamped;

    assign w_accept     = cfg_valid && (r_state == ST_IDLE);
    // abort takes priority over a bit arriving in the same cycle.
    assign w_shift      = (r_state == ST_ARMED) && in_valid && !abort;
    assign w_take       = w_shift && w_core_match;
    assign w_clear_core = ((r_state == ST_IDLE) && start) || ((r_state == ST_ARMED) && abort);
    assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_len_clamped = cfg_len;
        if (cfg_len == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_W'(PAT_W)) begin
            w_len_clamped = LEN_W'(PAT_W);
        end
    end

    seq_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear_core),
        .i_shift     (w_shift),
        .i_fill_zero (w_take && !r_overlap),
        .i_bit       (in),
        .i_pattern   (r_pattern),
        .i_len       (r_len),
        .o_match     (w_core_match)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_take && (r_target != '0) && (w_cnt_inc == r_target)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (clear) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= '0;
            r_len     <= LEN_W'(1);
            r_overlap <= 1'b0;
            r_target  <= '0;
        end else if (w_accept) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= cfg_overlap;
            r_target  <= cfg_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_out <= w_take;
            if ((r_state == ST_IDLE) && start) begin
                r_cnt <= '0;
            end else if (w_take) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign cfg_ready   = (r_state == ST_IDLE);
    assign out         = r_out;
    assign match_cnt   = r_cnt;
    assign busy        = (r_state == ST_ARMED);
    assign done        = (r_state == ST_DONE);
    assign o_state_dbg = r_state;

endmodule
